// File: rtl/cubehash_ctrl_if.sv
// Handshake and data bundle between the CubeHash session controller, the
// byte assembler and the round core.
interface cubehash_ctrl_if;
  logic         msg_start;
  logic         blk_done;
  logic [255:0] blk_data;
  logic         msg_last;
  logic         round_ack;
  logic         core_init;
  logic         xor_en;
  logic [255:0] xor_data;
  logic         fin_flip;
  logic         round_go;
  logic         asm_en;
  logic         busy;
  logic         digest_valid;
  logic         overflow;

  // Environment side: assembler, core and session start.
  modport master (
    output msg_start, blk_done, blk_data, msg_last, round_ack,
    input  core_init, xor_en, xor_data, fin_flip, round_go,
           asm_en, busy, digest_valid, overflow
  );

  // Controller side.
  modport slave (
    input  msg_start, blk_done, blk_data, msg_last, round_ack,
    output core_init, xor_en, xor_data, fin_flip, round_go,
           asm_en, busy, digest_valid, overflow
  );
endinterface

// File: rtl/cubehash_ctrl.sv
// CubeHash session controller: one-entry block buffer plus the sequencer
// that drives the round core through init, absorb/rounds, flip and final.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no session since reset
// INIT     | core_init on entry cycle, then I_ROUNDS rounds
// WAIT_BLK | waiting for the buffer to hold a block
// ABSORB   | one cycle, xor_en with the buffered block, buffer consumed
// ROUNDS   | R_ROUNDS rounds after an absorb
// FLIP     | one cycle, fin_flip
// FINAL    | F_ROUNDS rounds after the flip
// DONE     | digest ready, waits for msg_start
module cubehash_ctrl #(
  parameter int unsigned I_ROUNDS = 160,
  parameter int unsigned R_ROUNDS = 16,
  parameter int unsigned F_ROUNDS = 160,
  parameter int unsigned CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_p,
  cubehash_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_BLK, S_ABSORB, S_ROUNDS, S_FLIP, S_FINAL, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             init_entry_q, init_entry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_q, go_d;
  logic             pend_q, pend_d;
  logic [255:0]     blk_buf_q, blk_buf_d;
  logic             buf_full_q, buf_full_d;
  logic             buf_last_q, buf_last_d;
  logic             abs_last_q, abs_last_d;
  logic             ovf_q, ovf_d;

  logic in_rounds, ack_ok, last_ack, active, blk_ok, consume;

  // A round is outstanding from its round_go until its ack; stray acks are dropped.
  assign in_rounds = ((state_q == S_INIT) && !init_entry_q) ||
                     (state_q == S_ROUNDS) || (state_q == S_FINAL);
  assign ack_ok    = in_rounds && bus.round_ack && (pend_q || go_q);
  assign last_ack  = ack_ok && (cnt_q == CNT_W'(1));
  assign active    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign blk_ok    = bus.blk_done && active;
  assign consume   = (state_q == S_ABSORB);

  assign bus.core_init    = (state_q == S_INIT) && init_entry_q;
  assign bus.xor_en       = consume;
  assign bus.xor_data     = consume ? blk_buf_q : '0;
  assign bus.fin_flip     = (state_q == S_FLIP);
  assign bus.round_go     = go_q;
  assign bus.busy         = active;
  assign bus.asm_en       = active && !buf_full_q;
  assign bus.digest_valid = (state_q == S_DONE);
  assign bus.overflow     = ovf_q;

  // Next-state: round counting, buffer fill/consume, phase sequencing, restart.
  always_comb begin
    state_d      = state_q;
    init_entry_d = init_entry_q;
    cnt_d        = cnt_q;
    go_d         = 1'b0;
    pend_d       = pend_q;
    blk_buf_d    = blk_buf_q;
    buf_full_d   = buf_full_q;
    buf_last_d   = buf_last_q;
    abs_last_d   = abs_last_q;
    ovf_d        = ovf_q;

    if (go_q) pend_d = 1'b1;
    if (ack_ok) begin
      pend_d = 1'b0;
      cnt_d  = cnt_q - CNT_W'(1);
      if (!last_ack) go_d = 1'b1;
    end

    if (consume) buf_full_d = 1'b0;
    if (blk_ok) begin
      if (buf_full_q && !consume) begin
        ovf_d = 1'b1;
      end else begin
        blk_buf_d  = bus.blk_data;
        buf_last_d = bus.msg_last;
        buf_full_d = 1'b1;
      end
    end

    case (state_q)
      S_INIT: begin
        if (init_entry_q) begin
          init_entry_d = 1'b0;
          cnt_d        = CNT_W'(I_ROUNDS);
          go_d         = 1'b1;
        end else if (last_ack) begin
          state_d = S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: if (buf_full_q || blk_ok) state_d = S_ABSORB;
      S_ABSORB: begin
        abs_last_d = buf_last_q;
        cnt_d      = CNT_W'(R_ROUNDS);
        go_d       = 1'b1;
        state_d    = S_ROUNDS;
      end
      S_ROUNDS: if (last_ack) state_d = abs_last_q ? S_FLIP : S_WAIT_BLK;
      S_FLIP: begin
        cnt_d   = CNT_W'(F_ROUNDS);
        go_d    = 1'b1;
        state_d = S_FINAL;
      end
      S_FINAL: if (last_ack) state_d = S_DONE;
      default: ;
    endcase

    // A new session wins over any same-cycle block or ack.
    if (bus.msg_start) begin
      state_d      = S_INIT;
      init_entry_d = 1'b1;
      cnt_d        = '0;
      go_d         = 1'b0;
      pend_d       = 1'b0;
      blk_buf_d    = '0;
      buf_full_d   = 1'b0;
      buf_last_d   = 1'b0;
      abs_last_d   = 1'b0;
      ovf_d        = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q      <= S_IDLE;
      init_entry_q <= 1'b0;
      cnt_q        <= '0;
      go_q         <= 1'b0;
      pend_q       <= 1'b0;
      blk_buf_q    <= '0;
      buf_full_q   <= 1'b0;
      buf_last_q   <= 1'b0;
      abs_last_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_entry_q <= init_entry_d;
      cnt_q        <= cnt_d;
      go_q         <= go_d;
      pend_q       <= pend_d;
      blk_buf_q    <= blk_buf_d;
      buf_full_q   <= buf_full_d;
      buf_last_q   <= buf_last_d;
      abs_last_q   <= abs_last_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cubehash_ctrl.sv
// Bench for cubehash_ctrl with I_ROUNDS=4, R_ROUNDS=2, F_ROUNDS=4 and a core
// that acks one cycle after each round_go. Expected core-side events (with
// their cycle spacing) are queued by the stimulus and consumed by a monitor.
module tb_cubehash_ctrl;

  typedef enum int {K_INIT, K_ROUND, K_XOR, K_FLIP, K_DONE} kind_e;
  typedef struct {
    kind_e        kind;
    logic [255:0] data;
    int           gap;
  } ev_t;

  logic clk;
  logic rst_p;
  cubehash_ctrl_if bus ();

  cubehash_ctrl #(.I_ROUNDS(4), .R_ROUNDS(2), .F_ROUNDS(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  ev_t sb_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  bit  prev_dv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: every round finishes one cycle after it is requested.
  always @(posedge clk) bus.round_ack <= bus.round_go;

  task automatic chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input kind_e k, input logic [255:0] d, input int g);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.gap  = g;
    sb_q.push_back(e);
  endfunction

  // n rounds: first one the cycle after a setup cycle, then every 2 cycles.
  function automatic void push_rounds(input int n);
    push(K_ROUND, '0, 1);
    for (int i = 1; i < n; i++) push(K_ROUND, '0, 2);
  endfunction

  function automatic void push_tail();
    push(K_FLIP, '0, 2);
    push_rounds(4);
    push(K_DONE, '0, 2);
  endfunction

  function automatic logic [255:0] mk_blk(input logic [7:0] base);
    logic [255:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i*8 +: 8] = base + 8'(i);
    return b;
  endfunction

  // Monitor: every core-side pulse (or digest_valid rise) must match the queue head.
  always @(negedge clk) begin : mon
    kind_e k;
    bit    seen;
    ev_t   e;
    seen = 1'b1;
    k    = K_INIT;
    if (bus.core_init)                         k = K_INIT;
    else if (bus.xor_en)                       k = K_XOR;
    else if (bus.fin_flip)                     k = K_FLIP;
    else if (bus.round_go)                     k = K_ROUND;
    else if (bus.digest_valid && !prev_dv)     k = K_DONE;
    else                                       seen = 1'b0;
    prev_dv = bus.digest_valid;
    if (seen) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, nothing expected", k, cyc);
      end else begin
        e = sb_q.pop_front();
        chk_i("event_kind", int'(k), int'(e.kind));
        if (e.kind == K_XOR) chk_w("xor_data", bus.xor_data, e.data);
        if (e.gap != 0) chk_i("event_spacing", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles", name, sb_q.size(), n);
      sb_q.delete();
    end
  endtask

  task automatic wait_xor(input string name);
    int n;
    n = 0;
    while (!bus.xor_en && n < 100) begin
      tick();
      n++;
    end
    if (!bus.xor_en) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: xor_en got 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic blk(input logic [255:0] d, input logic last);
    bus.blk_done = 1'b1;
    bus.blk_data = d;
    bus.msg_last = last;
    tick();
    bus.blk_done = 1'b0;
    bus.msg_last = 1'b0;
  endtask

  task automatic check_idle(input string name);
    chk1({name, "_core_init"}, bus.core_init, 1'b0);
    chk1({name, "_xor_en"}, bus.xor_en, 1'b0);
    chk_w({name, "_xor_data"}, bus.xor_data, '0);
    chk1({name, "_fin_flip"}, bus.fin_flip, 1'b0);
    chk1({name, "_round_go"}, bus.round_go, 1'b0);
    chk1({name, "_asm_en"}, bus.asm_en, 1'b0);
    chk1({name, "_busy"}, bus.busy, 1'b0);
    chk1({name, "_digest_valid"}, bus.digest_valid, 1'b0);
    chk1({name, "_overflow"}, bus.overflow, 1'b0);
  endtask

  task automatic start_session(input string name);
    push(K_INIT, '0, 0);
    push_rounds(4);
    bus.msg_start = 1'b1;
    tick();
    bus.msg_start = 1'b0;
    chk1({name, "_busy"}, bus.busy, 1'b1);
    chk1({name, "_asm_en"}, bus.asm_en, 1'b1);
    chk1({name, "_digest_cleared"}, bus.digest_valid, 1'b0);
    chk1({name, "_overflow_cleared"}, bus.overflow, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] b0, b1, b2, b3;
    b0 = mk_blk(8'h00);
    b1 = mk_blk(8'h40);
    b2 = mk_blk(8'h80);
    b3 = mk_blk(8'hC0);
    rst_p         = 1'b1;
    bus.msg_start = 1'b0;
    bus.blk_done  = 1'b0;
    bus.blk_data  = '0;
    bus.msg_last  = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst_p = 1'b0;
    tick();
    check_idle("idle");

    // Single last block.
    start_session("a");
    wait_drain("a_init");
    push(K_XOR, b0, 0);
    push_rounds(2);
    push_tail();
    blk(b0, 1'b1);
    wait_drain("a_run");
    chk1("a_digest_valid", bus.digest_valid, 1'b1);
    chk1("a_busy", bus.busy, 1'b0);
    chk1("a_asm_en", bus.asm_en, 1'b0);
    chk1("a_overflow", bus.overflow, 1'b0);

    // Three blocks, each delivered while the previous one is being processed.
    start_session("b");
    push(K_XOR, b1, 3); push_rounds(2);
    push(K_XOR, b2, 3); push_rounds(2);
    push(K_XOR, b3, 3); push_rounds(2);
    push_tail();
    tick();
    blk(b1, 1'b0);
    wait_xor("b_xor1");
    tick();
    blk(b2, 1'b0);
    wait_xor("b_xor2");
    tick();
    blk(b3, 1'b1);
    wait_drain("b_run");
    chk1("b_overflow", bus.overflow, 1'b0);
    chk1("b_digest_valid", bus.digest_valid, 1'b1);

    // Two blocks back to back during INIT: second one is dropped.
    start_session("c");
    push(K_XOR, b2, 3);
    push_rounds(2);
    push_tail();
    tick();
    blk(b2, 1'b1);
    chk1("c_asm_en_full", bus.asm_en, 1'b0);
    blk(b3, 1'b0);
    chk1("c_overflow_set", bus.overflow, 1'b1);
    chk1("c_asm_en_still_full", bus.asm_en, 1'b0);
    wait_drain("c_run");
    chk1("c_overflow_sticky", bus.overflow, 1'b1);
    chk1("c_digest_valid", bus.digest_valid, 1'b1);

    // Block arriving in the exact ABSORB cycle refills the buffer.
    start_session("d");
    wait_drain("d_init");
    push(K_XOR, b1, 0); push_rounds(2);
    push(K_XOR, b3, 3); push_rounds(2);
    push_tail();
    blk(b1, 1'b0);
    wait_xor("d_xor1");
    blk(b3, 1'b1);
    chk1("d_overflow_refill", bus.overflow, 1'b0);
    chk1("d_asm_en_refilled", bus.asm_en, 1'b0);
    wait_drain("d_run");
    chk1("d_overflow_end", bus.overflow, 1'b0);
    chk1("d_digest_valid", bus.digest_valid, 1'b1);

    // msg_start during FINAL, with overflow set, restarts cleanly.
    start_session("e");
    push(K_XOR, b0, 3);
    push_rounds(2);
    push(K_FLIP, '0, 2);
    push_rounds(2);
    tick();
    blk(b0, 1'b1);
    blk(b1, 1'b0);
    wait_drain("e_to_final");
    chk1("e_overflow_before", bus.overflow, 1'b1);
    start_session("e_restart");
    wait_drain("e_init");
    push(K_XOR, b2, 0);
    push_rounds(2);
    push_tail();
    blk(b2, 1'b1);
    wait_drain("e_run");
    chk1("e_digest_valid", bus.digest_valid, 1'b1);
    chk1("e_overflow_end", bus.overflow, 1'b0);

    // Reset in the middle of ROUNDS, with an ack still in flight.
    start_session("f");
    wait_drain("f_init");
    push(K_XOR, b3, 0);
    push(K_ROUND, '0, 1);
    blk(b3, 1'b0);
    wait_drain("f_to_rounds");
    rst_p = 1'b1;
    tick();
    check_idle("f_rst");
    rst_p = 1'b0;
    tick();
    check_idle("f_after_rst");
    start_session("f_restart");
    wait_drain("f_init2");
    push(K_XOR, b1, 0);
    push_rounds(2);
    push_tail();
    blk(b1, 1'b1);
    wait_drain("f_run");
    chk1("f_digest_valid", bus.digest_valid, 1'b1);
    chk1("f_busy", bus.busy, 1'b0);

    repeat (4) tick();
    chk_i("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cubehash_ctrl.md
# cubehash_ctrl

Session controller for the CubeHash engine. It takes completed 256-bit message blocks from the byte assembler (`blk_done` pulse plus block bus) and holds them in a one-entry buffer. It sequences the round core through initialisation, per-block absorb-and-round, the finalisation flip and the final rounds, then raises `digest_valid`. It also drives the assembler's enable so bytes only flow while the buffer has room.

## Interface
- `I_ROUNDS`, default 160: rounds run after the core state load.
- `R_ROUNDS`, default 16: rounds run per absorbed block.
- `F_ROUNDS`, default 160: rounds run after the finalisation flip.
- `CNT_W`, default 8: round counter width. It must hold the largest of the three round parameters.
- `clk` in 1: single system clock (100 MHz).
- `rst_p` in 1: reset; synchronous, active high.
- `msg_start` in 1: pulse; begins a new hash session and aborts any session in progress.
- `blk_done` in 1: pulse from the assembler; the block on `blk_data` is complete.
- `blk_data` in 256: assembled block, sampled on `blk_done`.
- `msg_last` in 1: sampled together with `blk_done`; 1 marks the final message block.
- `round_ack` in 1: pulse from the core; the requested round has finished.
- `core_init` out 1: pulse; core loads its IV state.
- `xor_en` out 1: pulse; core XORs `xor_data` into state words 0..7.
- `xor_data` out 256: block being absorbed; valid while `xor_en` = 1.
- `fin_flip` out 1: pulse; core XORs 1 into state word 31.
- `round_go` out 1: pulse; core performs exactly one round.
- `asm_en` out 1: enable to the assembler's `in_en`.
- `busy` out 1: session active (state not IDLE and not DONE).
- `digest_valid` out 1: level; the core state holds the final digest.
- `overflow` out 1: sticky; a block arrived while the buffer was full.

## Operation
- States:
  - IDLE → INIT on `msg_start`.
  - INIT: `core_init` pulses on the entry cycle, then `I_ROUNDS` rounds run, then → WAIT_BLK.
  - WAIT_BLK → ABSORB when the buffer is full.
  - ABSORB (1 cycle, `xor_en` = 1, buffer consumed) → ROUNDS.
  - ROUNDS: after `R_ROUNDS` rounds, → FLIP if the absorbed block was last, else → WAIT_BLK.
  - FLIP (1 cycle, `fin_flip` = 1) → FINAL.
  - FINAL: after `F_ROUNDS` rounds, → DONE.
  - DONE → INIT on `msg_start`.
- Round sequencing (INIT after the entry cycle, ROUNDS, FINAL):
  - Counter loads the round parameter.
  - `round_go` pulses on the first cycle the state is eligible, and again the cycle after each `round_ack` while the count is nonzero.
  - Each `round_ack` decrements the counter. The ack that takes it to 0 causes the state transition on the next edge.
  - At most one round is outstanding. A `round_ack` with none outstanding is ignored.
- Buffer: holds `blk_buf` (256 bits), `buf_last` and `buf_full`.
  - `blk_done` is accepted in INIT, WAIT_BLK, ABSORB, ROUNDS, FLIP and FINAL. It is ignored in IDLE and DONE.
  - `blk_done` with `buf_full` = 1 and no consume that cycle: block dropped, `overflow` set.
  - `blk_done` in the ABSORB cycle: buffer refills, no overflow.
  - A block arriving after the last block was absorbed, but before DONE: counts as overflow if the buffer is full, otherwise buffered and discarded at the next `msg_start`.
- `asm_en` = `busy` & !`buf_full`.
- `msg_start` in any state: counter, buffer and `overflow` clear, `digest_valid` drops, state → INIT. This takes priority over a simultaneous `blk_done` or `round_ack`.
- `xor_data` = `blk_buf` during ABSORB, 0 otherwise.

## Timing
- Reset values:
  - State IDLE.
  - All pulse outputs 0, `xor_data` 0.
  - `asm_en`, `busy`, `digest_valid`, `overflow` all 0.
  - Buffer empty, counter 0.
- `msg_start` sampled at edge N: `core_init` = 1 in cycle N+1, first `round_go` in cycle N+2.
- `blk_done` at edge N while in WAIT_BLK: `xor_en` in cycle N+1, first `round_go` in cycle N+2.
- Core returning `round_ack` k cycles after `round_go`: round period k+1 cycles.
- DONE is entered the cycle after the final ack of FINAL. `digest_valid` = 1 from that cycle until `msg_start` or reset.
- `rst_p` mid-session: everything returns to reset values at the next edge. Pending acks are discarded.

## Test plan
- Bench setup: `I_ROUNDS`=4, `R_ROUNDS`=2, `F_ROUNDS`=4. Core model acks 1 cycle after `round_go`.
- Reset, then `msg_start` → `core_init` one cycle, 4 `round_go` pulses 2 cycles apart, `asm_en` = 1.
- One block 0x00..1F with `msg_last`=1 → `xor_data` equals the block during the single `xor_en` cycle; 2 rounds; `fin_flip` once; 4 rounds; `digest_valid` = 1 and `busy` = 0.
- Three blocks, the third marked last, each arriving during rounds → `xor_en` ×3 in order, 6 per-block rounds, `overflow` = 0.
- Two `blk_done` pulses during INIT → first block buffered, second sets `overflow` = 1; `asm_en` = 0 while the buffer is full.
- `blk_done` in the exact ABSORB cycle → buffer refills, `overflow` stays 0, next ABSORB follows after 2 rounds.
- `msg_start` mid-FINAL, and separately `rst_p` mid-ROUNDS → restart at INIT with `digest_valid`/`overflow` cleared; after reset, all outputs 0.
